answer_checker: RTL and testbench
=================================

# answer_checker

Player-answer side of the symbol-counting game. When the generation period ends, this block opens a timed answer window. During the window the player dials in a guess of the special-symbol count with up/down buttons and submits it. The block compares the guess against the count latched at period end, then reports correct, wrong or timeout and keeps a running score and streak. It sits between the game-period block and the display/LED logic, all in the 100 MHz domain.

## Interface
Parameters:
- ANSWER_SECS, 10, length of the answer window in 1 Hz ticks (1..255)
- RESULT_SECS, 3, how long the result is held before returning to idle (1..255)

Ports:
- Clk100M  in  1  system clock; one clock; reset is asynchronous and active-low
- Rst_n  in  1  asynchronous active-low reset
- tick1Hz  in  1  one-Clk100M-cycle enable pulse, once per second
- stopGen  in  1  one-cycle pulse marking the end of the generation period
- numSpecial  in  8  special-symbol count; sampled on the stopGen cycle
- btnUp, btnDown, btnSubmit  in  1 each  debounced one-cycle pulses
- clearScore  in  1  one-cycle pulse that zeroes score and streak
- answerSig  out  1  high while the answer window is open
- guess  out  8  current guess
- secsLeft  out  8  whole seconds left in the current window (answer or result)
- resultValid  out  1  high while in RESULT
- correct, wrong, timedOut  out  1 each  result flags, held for the whole of RESULT
- score  out  8  count of correct answers, saturating
- streak  out  8  consecutive correct answers, saturating

## Operation
- States: IDLE, ANSWER, CHECK, RESULT.
- Reset: state IDLE; every output 0; internal target register 0.
- IDLE, on stopGen:
  - latch numSpecial into target
  - set guess to 0 and secsLeft to ANSWER_SECS
  - go to ANSWER
- IDLE, other inputs: btnUp/btnDown/btnSubmit ignored.
- ANSWER, answerSig=1:
  - btnUp: guess+1, saturating at 255.
  - btnDown: guess-1, saturating at 0.
  - btnUp and btnDown in the same cycle: guess unchanged.
  - btnSubmit: go to CHECK. The guess compared is the registered value; an up/down pulse in the same cycle is discarded.
  - tick1Hz: decrement secsLeft. If secsLeft was 1, go to CHECK with timeout set.
  - btnSubmit and the final tick in the same cycle: the submit wins; not a timeout.
- CHECK (1 cycle):
  - correct = !timeout && guess==target
  - wrong = !correct
  - timedOut = timeout
  - on correct: score and streak each +1, saturating at 255
  - on wrong or timeout: streak = 0; score unchanged
  - set secsLeft to RESULT_SECS and go to RESULT
- RESULT:
  - resultValid=1; flags held; guess held.
  - tick1Hz decrements secsLeft. At 1→0, go to IDLE and clear correct, wrong, timedOut and resultValid.
- stopGen outside IDLE: ignored; target is not re-latched.
- clearScore: takes effect in any state. It overrides a CHECK increment in the same cycle, leaving score=0 and streak=0.
- Reset asserted mid-window: immediate return to the reset values; no result is produced.

## Timing
- stopGen at cycle N → answerSig=1 at N+1.
- Submit at cycle N → CHECK at N+1 → resultValid and flags visible at N+2; score and streak also updated at N+2.
- Timeout: the tick that brings secsLeft to 0 at cycle N → resultValid at N+2.
- RESULT lasts exactly RESULT_SECS ticks. IDLE is reached the cycle after the last tick.
- All outputs are registered; no combinational input→output paths.

## Structure
- Shared package game_pkg:
  - enum ans_state_t {IDLE, ANSWER, CHECK, RESULT}
  - localparam CNT_W=8
  - a saturating-increment function reused by the score and streak logic
- One natural sub-module: sec_countdown. It loads an 8-bit value, decrements on tick1Hz, and raises a `done` pulse on the 1→0 transition. It is instantiated once and reloaded between ANSWER and RESULT.

## Test plan
- numSpecial=5 at stopGen, 5× btnUp, submit → correct=1, score=1, streak=1 for 3 ticks, then IDLE.
- Guess 4 against target 5, submit → wrong=1, streak=0, score unchanged.
- Issue no submit for 10 ticks → timedOut=1, wrong=1 at the 10th tick+2 cycles. Then repeat with submit on the same cycle as the 10th tick → timedOut=0.
- Saturation: btnDown at guess 0 → stays 0. 300× btnUp → stays 255. Score preloaded at 255 via 255 correct rounds, then a further correct answer → stays 255.
- btnUp and btnDown in the same cycle → guess unchanged. stopGen with numSpecial=9 during ANSWER → target stays at the original value.
- Rst_n asserted mid-ANSWER → all outputs 0 asynchronously. clearScore in the CHECK cycle of a correct answer → score=0, streak=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the symbol-counting game blocks.
package game_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ANSWER = 2'd1,
        CHECK  = 2'd2,
        RESULT = 2'd3
    } ans_state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Decrement that sticks at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

endpackage

// File: rtl/sec_countdown.sv
// Whole-second countdown: loadable, decremented by the 1 Hz enable,
// with a same-cycle done pulse on the tick that takes it from 1 to 0.
module sec_countdown
    import game_pkg::*;
(
    input  logic             Clk100M,
    input  logic             Rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             tick1Hz,
    output logic [CNT_W-1:0] secsLeft,
    output logic             done
);

    // done is combinational so the owner can change state on the final
    // tick itself; the count it is derived from is registered.
    assign done = tick1Hz && (secsLeft == CNT_W'(1));

    // Load has priority; otherwise count down on each tick and rest at zero.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            secsLeft <= '0;
        end else if (load) begin
            secsLeft <= loadVal;
        end else if (tick1Hz && (secsLeft != '0)) begin
            secsLeft <= secsLeft - 1'b1;
        end
    end

endmodule

// File: rtl/answer_checker.sv
// Player answer window: collects a guess, compares it with the count
// latched at the end of generation, and keeps score and streak.
module answer_checker
    import game_pkg::*;
#(
    parameter int ANSWER_SECS = 10,
    parameter int RESULT_SECS = 3
) (
    input  logic             Clk100M,
    input  logic             Rst_n,
    input  logic             tick1Hz,
    input  logic             stopGen,
    input  logic [CNT_W-1:0] numSpecial,
    input  logic             btnUp,
    input  logic             btnDown,
    input  logic             btnSubmit,
    input  logic             clearScore,
    output logic             answerSig,
    output logic [CNT_W-1:0] guess,
    output logic [CNT_W-1:0] secsLeft,
    output logic             resultValid,
    output logic             correct,
    output logic             wrong,
    output logic             timedOut,
    output logic [CNT_W-1:0] score,
    output logic [CNT_W-1:0] streak
);

    localparam logic [CNT_W-1:0] ANS_LOAD = CNT_W'(ANSWER_SECS);
    localparam logic [CNT_W-1:0] RES_LOAD = CNT_W'(RESULT_SECS);

    ans_state_t       state;
    ans_state_t       stateNext;
    logic [CNT_W-1:0] target;
    logic             timeoutFlag;
    logic             isCorrect;
    logic             cntLoad;
    logic [CNT_W-1:0] cntLoadVal;
    logic             cntDone;

    // A timeout can never be correct, whatever the guess happens to be.
    assign isCorrect = !timeoutFlag && (guess == target);

    sec_countdown u_countdown (
        .Clk100M  (Clk100M),
        .Rst_n    (Rst_n),
        .load     (cntLoad),
        .loadVal  (cntLoadVal),
        .tick1Hz  (tick1Hz),
        .secsLeft (secsLeft),
        .done     (cntDone)
    );

    // Reload the single countdown when a window opens and when the result is shown.
    always_comb begin
        cntLoad    = 1'b0;
        cntLoadVal = ANS_LOAD;
        if (state == IDLE && stopGen) begin
            cntLoad    = 1'b1;
            cntLoadVal = ANS_LOAD;
        end else if (state == CHECK) begin
            cntLoad    = 1'b1;
            cntLoadVal = RES_LOAD;
        end
    end

    // Next-state logic; submit and timeout both lead to the one-cycle CHECK.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (stopGen) stateNext = ANSWER;
            ANSWER:  if (btnSubmit || cntDone) stateNext = CHECK;
            CHECK:   stateNext = RESULT;
            RESULT:  if (cntDone) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register, registered window flags, target latch and timeout cause.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            answerSig   <= 1'b0;
            resultValid <= 1'b0;
            target      <= '0;
            timeoutFlag <= 1'b0;
        end else begin
            state       <= stateNext;
            answerSig   <= (stateNext == ANSWER);
            resultValid <= (stateNext == RESULT);
            if (state == IDLE && stopGen) begin
                target      <= numSpecial;
                timeoutFlag <= 1'b0;
            end else if (state == ANSWER) begin
                // A submit on the final tick counts as a real answer.
                timeoutFlag <= cntDone && !btnSubmit;
            end
        end
    end

    // Guess dial: cleared when a window opens; a submit freezes it for that cycle.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            guess <= '0;
        end else if (state == IDLE && stopGen) begin
            guess <= '0;
        end else if (state == ANSWER && !btnSubmit) begin
            if (btnUp && !btnDown) begin
                guess <= sat_inc(guess);
            end else if (btnDown && !btnUp) begin
                guess <= sat_dec(guess);
            end
        end
    end

    // Result flags are captured in CHECK and dropped when RESULT expires.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            correct  <= 1'b0;
            wrong    <= 1'b0;
            timedOut <= 1'b0;
        end else if (state == CHECK) begin
            correct  <= isCorrect;
            wrong    <= !isCorrect;
            timedOut <= timeoutFlag;
        end else if (state == RESULT && cntDone) begin
            correct  <= 1'b0;
            wrong    <= 1'b0;
            timedOut <= 1'b0;
        end
    end

    // Score keeping; a clear request beats a same-cycle CHECK update.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            score  <= '0;
            streak <= '0;
        end else if (clearScore) begin
            score  <= '0;
            streak <= '0;
        end else if (state == CHECK) begin
            if (isCorrect) begin
                score  <= sat_inc(score);
                streak <= sat_inc(streak);
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: tb/tb_answer_checker.sv
// Self-checking bench for answer_checker (default 10 s answer, 3 s result).
`timescale 1ns/1ps
module tb_answer_checker;

    logic       Clk100M = 1'b0;
    logic       Rst_n = 1'b0;
    logic       tick1Hz = 1'b0, stopGen = 1'b0;
    logic       btnUp = 1'b0, btnDown = 1'b0, btnSubmit = 1'b0, clearScore = 1'b0;
    logic [7:0] numSpecial = 8'd0;
    logic       answerSig, resultValid, correct, wrong, timedOut;
    logic [7:0] guess, secsLeft, score, streak;

    int total = 0;
    int bad   = 0;

    // Input bit positions: {up, down, submit, tick, stopGen, clear}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] UP   = 6'b100000;
    localparam logic [5:0] DN   = 6'b010000;
    localparam logic [5:0] SUB  = 6'b001000;
    localparam logic [5:0] TK   = 6'b000100;
    localparam logic [5:0] SG   = 6'b000010;
    localparam logic [5:0] CLR  = 6'b000001;

    typedef struct {
        logic [5:0] in;
        logic [7:0] ns;
        int ans, g, s, rv, c, w, to, sc, st;
    } vec_t;
    vec_t vq[$];

    answer_checker #(.ANSWER_SECS(10), .RESULT_SECS(3)) dut (
        .Clk100M     (Clk100M),
        .Rst_n       (Rst_n),
        .tick1Hz     (tick1Hz),
        .stopGen     (stopGen),
        .numSpecial  (numSpecial),
        .btnUp       (btnUp),
        .btnDown     (btnDown),
        .btnSubmit   (btnSubmit),
        .clearScore  (clearScore),
        .answerSig   (answerSig),
        .guess       (guess),
        .secsLeft    (secsLeft),
        .resultValid (resultValid),
        .correct     (correct),
        .wrong       (wrong),
        .timedOut    (timedOut),
        .score       (score),
        .streak      (streak)
    );

    always #5 Clk100M = ~Clk100M;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic checkOut(input string tag, input int ans, g, s, rv, c, w, to, sc, st);
        chk({tag, ".answerSig"},   32'(answerSig),   ans);
        chk({tag, ".guess"},       32'(guess),       g);
        chk({tag, ".secsLeft"},    32'(secsLeft),    s);
        chk({tag, ".resultValid"}, 32'(resultValid), rv);
        chk({tag, ".correct"},     32'(correct),     c);
        chk({tag, ".wrong"},       32'(wrong),       w);
        chk({tag, ".timedOut"},    32'(timedOut),    to);
        chk({tag, ".score"},       32'(score),       sc);
        chk({tag, ".streak"},      32'(streak),      st);
    endtask

    // Present one cycle of inputs (from a negedge), then return them to zero.
    task automatic step(input logic [5:0] in, input logic [7:0] ns);
        {btnUp, btnDown, btnSubmit, tick1Hz, stopGen, clearScore} = in;
        numSpecial = ns;
        @(negedge Clk100M);
        {btnUp, btnDown, btnSubmit, tick1Hz, stopGen, clearScore} = 6'b0;
        numSpecial = 8'd0;
    endtask

    task automatic addv(input logic [5:0] in, input logic [7:0] ns,
                        input int ans, g, s, rv, c, w, to, sc, st);
        vec_t v;
        v.in = in; v.ns = ns;
        v.ans = ans; v.g = g; v.s = s; v.rv = rv; v.c = c; v.w = w; v.to = to;
        v.sc = sc; v.st = st;
        vq.push_back(v);
    endtask

    task automatic correctRound();
        step(SG, 8'd0);
        step(SUB, 8'd0);
        step(NONE, 8'd0);
        repeat (3) step(TK, 8'd0);
    endtask

    initial begin
        int mScore, mStreak;

        // ---------------- fill vector table ----------------
        addv(SG, 8'd5, 1, 0, 10, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) addv(UP, 8'd0, 1, i, 10, 0, 0, 0, 0, 0, 0);
        addv(SUB,  8'd0, 0, 5, 10, 0, 0, 0, 0, 0, 0);
        addv(NONE, 8'd0, 0, 5, 3, 1, 1, 0, 0, 1, 1);
        addv(TK,   8'd0, 0, 5, 2, 1, 1, 0, 0, 1, 1);
        addv(TK,   8'd0, 0, 5, 1, 1, 1, 0, 0, 1, 1);
        addv(TK,   8'd0, 0, 5, 0, 0, 0, 0, 0, 1, 1);
        addv(SG, 8'd5, 1, 0, 10, 0, 0, 0, 0, 1, 1);
        for (int i = 1; i <= 4; i++) addv(UP, 8'd0, 1, i, 10, 0, 0, 0, 0, 1, 1);
        addv(SUB,  8'd0, 0, 4, 10, 0, 0, 0, 0, 1, 1);
        addv(NONE, 8'd0, 0, 4, 3, 1, 0, 1, 0, 1, 0);
        addv(TK,   8'd0, 0, 4, 2, 1, 0, 1, 0, 1, 0);
        addv(TK,   8'd0, 0, 4, 1, 1, 0, 1, 0, 1, 0);
        addv(TK,   8'd0, 0, 4, 0, 0, 0, 0, 0, 1, 0);

        // ---------------- reset ----------------
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk100M);
        checkOut("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        Rst_n = 1'b1;
        @(negedge Clk100M);
        checkOut("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(UP | DN | SUB, 8'd0);
        checkOut("idle_btn", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- table-driven rounds ----------------
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].in, vq[i].ns);
            checkOut($sformatf("vec%0d", i), vq[i].ans, vq[i].g, vq[i].s, vq[i].rv,
                     vq[i].c, vq[i].w, vq[i].to, vq[i].sc, vq[i].st);
        end

        // ---------------- timeout ----------------
        step(SG, 8'd7);
        for (int i = 1; i <= 9; i++) begin
            step(TK, 8'd0);
            chk($sformatf("to_secs%0d", i), 32'(secsLeft), 10 - i);
        end
        step(TK, 8'd0);
        chk("to_check.answerSig", 32'(answerSig), 0);
        chk("to_check.resultValid", 32'(resultValid), 0);
        step(NONE, 8'd0);
        checkOut("timeout", 0, 0, 3, 1, 0, 1, 1, 1, 0);
        repeat (3) step(TK, 8'd0);
        chk("to_end.resultValid", 32'(resultValid), 0);

        // ---------------- submit on the final tick ----------------
        step(SG, 8'd0);
        repeat (9) step(TK, 8'd0);
        step(SUB | TK, 8'd0);
        step(NONE, 8'd0);
        checkOut("sub_final_tick", 0, 0, 3, 1, 1, 0, 0, 2, 1);
        repeat (3) step(TK, 8'd0);

        // ---------------- guess saturation, up+down, stopGen ignored ----------------
        step(SG, 8'd254);
        step(DN, 8'd0);
        chk("sat_down0", 32'(guess), 0);
        repeat (300) step(UP, 8'd0);
        chk("sat_up255", 32'(guess), 255);
        step(DN, 8'd0);
        chk("dn_254", 32'(guess), 254);
        step(UP | DN, 8'd0);
        chk("updn_same", 32'(guess), 254);
        step(SG, 8'd9);
        chk("sg_in_answer.answerSig", 32'(answerSig), 1);
        chk("sg_in_answer.secsLeft", 32'(secsLeft), 10);
        step(SUB, 8'd0);
        step(NONE, 8'd0);
        checkOut("target_kept", 0, 254, 3, 1, 1, 0, 0, 3, 2);
        repeat (3) step(TK, 8'd0);

        // ---------------- clearScore in the CHECK cycle ----------------
        step(SG, 8'd3);
        repeat (3) step(UP, 8'd0);
        step(SUB, 8'd0);
        step(CLR, 8'd0);
        checkOut("clr_in_check", 0, 3, 3, 1, 1, 0, 0, 0, 0);
        repeat (3) step(TK, 8'd0);
        mScore = 0;
        mStreak = 0;

        // ---------------- randomized rounds vs. reference model ----------------
        for (int r = 0; r < 40; r++) begin
            int t, g, secs, n, sel, to, clr, corr;
            logic up, dn, tk;
            t = int'($urandom_range(0, 10));
            step(SG, 8'(t));
            g = 0;
            secs = 10;
            n = int'($urandom_range(0, 14));
            for (int k = 0; k < n; k++) begin
                sel = int'($urandom_range(0, 4));
                up = (sel == 0) || (sel == 3);
                dn = (sel == 1) || (sel == 3);
                tk = (secs > 1) && ($urandom_range(0, 3) == 0);
                step({up, dn, 1'b0, tk, 2'b00}, 8'd0);
                if (up && !dn) g = (g < 255) ? g + 1 : 255;
                if (dn && !up) g = (g > 0) ? g - 1 : 0;
                if (tk) secs--;
            end
            chk($sformatf("rnd%0d.guess", r), 32'(guess), g);
            chk($sformatf("rnd%0d.secsLeft", r), 32'(secsLeft), secs);
            to = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if (to != 0) repeat (secs) step(TK, 8'd0);
            else step(SUB, 8'd0);
            clr = ($urandom_range(0, 7) == 0) ? 1 : 0;
            step(clr != 0 ? CLR : NONE, 8'd0);
            corr = (to == 0 && g == t) ? 1 : 0;
            if (corr != 0) begin
                mScore  = (mScore  < 255) ? mScore  + 1 : 255;
                mStreak = (mStreak < 255) ? mStreak + 1 : 255;
            end else begin
                mStreak = 0;
            end
            if (clr != 0) begin
                mScore = 0;
                mStreak = 0;
            end
            checkOut($sformatf("rnd%0d", r), 0, g, 3, 1, corr, 1 - corr, to, mScore, mStreak);
            repeat (3) step(TK, 8'd0);
            chk($sformatf("rnd%0d.end", r), 32'(resultValid), 0);
        end

        // ---------------- score/streak saturation ----------------
        step(CLR, 8'd0);
        chk("clr_idle.score", 32'(score), 0);
        chk("clr_idle.streak", 32'(streak), 0);
        repeat (255) correctRound();
        chk("pre_sat.score", 32'(score), 255);
        chk("pre_sat.streak", 32'(streak), 255);
        step(SG, 8'd0);
        step(SUB, 8'd0);
        step(NONE, 8'd0);
        checkOut("score_sat", 0, 0, 3, 1, 1, 0, 0, 255, 255);
        repeat (3) step(TK, 8'd0);

        // ---------------- asynchronous reset mid-ANSWER ----------------
        step(SG, 8'd4);
        repeat (3) step(UP, 8'd0);
        #2 Rst_n = 1'b0;
        #1 checkOut("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk100M);
        Rst_n = 1'b1;
        step(NONE, 8'd0);
        checkOut("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
